// File: rtl/usb_ctl_pkg.sv
// Shared definitions for the endpoint-0 standard-request engine: request codes,
// descriptor table, the compiled-in descriptor image and the FSM state type.
package usb_ctl_pkg;

    localparam logic [7:0] REQ_GET_STATUS        = 8'd0;
    localparam logic [7:0] REQ_SET_ADDRESS       = 8'd5;
    localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'd6;
    localparam logic [7:0] REQ_GET_CONFIGURATION = 8'd8;
    localparam logic [7:0] REQ_SET_CONFIGURATION = 8'd9;

    localparam logic [7:0] DESC_TYPE_DEVICE = 8'd1;
    localparam logic [7:0] DESC_TYPE_CONFIG = 8'd2;
    localparam logic [7:0] DESC_TYPE_STRING = 8'd3;

    localparam logic [7:0]  DESC_DEV_OFS = 8'd0;
    localparam logic [15:0] DESC_DEV_LEN = 16'd18;
    localparam logic [7:0]  DESC_CFG_OFS = 8'd18;
    localparam logic [15:0] DESC_CFG_LEN = 16'd34;

    localparam logic [7:0]  NUM_STR = 8'd2;
    localparam int          STR_IW  = $clog2(NUM_STR);
    localparam logic [7:0]  STR_OFS [NUM_STR] = '{8'd52, 8'd56};
    localparam logic [15:0] STR_LEN [NUM_STR] = '{16'd4, 16'd10};

    localparam int DESC_BYTES = 66;
    localparam int DESC_AW    = $clog2(DESC_BYTES);

    // Device (18) | configuration+interface+HID+endpoint (34) | string 0 (4) | string 1 "Acme" (10)
    localparam logic [7:0] DESC_IMAGE [DESC_BYTES] = '{
        8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34, 8'h12,
        8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01,
        8'h09, 8'h02, 8'h22, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32,
        8'h09, 8'h04, 8'h00, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00,
        8'h09, 8'h21, 8'h11, 8'h01, 8'h00, 8'h01, 8'h22, 8'h3F, 8'h00,
        8'h07, 8'h05, 8'h81, 8'h03, 8'h08, 8'h00, 8'h0A,
        8'h04, 8'h03, 8'h09, 8'h04,
        8'h0A, 8'h03, 8'h41, 8'h00, 8'h63, 8'h00, 8'h6D, 8'h00, 8'h65, 8'h00
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_PREFETCH,
        ST_SEND,
        ST_DRAIN,
        ST_WAIT_DONE,
        ST_STALL
    } ctl_state_e;

    typedef enum logic [1:0] {
        COMMIT_NONE,
        COMMIT_ADDR,
        COMMIT_CFG
    } commit_e;

    typedef struct packed {
        logic [3:0]  endpoint;
        logic [7:0]  request_type;
        logic [7:0]  request;
        logic [15:0] value;
        logic [15:0] length;
    } setup_t;

    typedef struct packed {
        logic        ok;
        logic [7:0]  ofs;
        logic [15:0] len;
    } desc_entry_t;

    function automatic desc_entry_t desc_lookup(input logic [15:0] w_value);
        desc_entry_t e;
        e = '0;
        case (w_value[15:8])
            DESC_TYPE_DEVICE: begin
                e.ok  = 1'b1;
                e.ofs = DESC_DEV_OFS;
                e.len = DESC_DEV_LEN;
            end
            DESC_TYPE_CONFIG: begin
                e.ok  = 1'b1;
                e.ofs = DESC_CFG_OFS;
                e.len = DESC_CFG_LEN;
            end
            DESC_TYPE_STRING: begin
                if (w_value[7:0] < NUM_STR) begin
                    e.ok  = 1'b1;
                    e.ofs = STR_OFS[w_value[STR_IW-1:0]];
                    e.len = STR_LEN[w_value[STR_IW-1:0]];
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [7:0] desc_byte(input logic [15:0] a);
        logic [7:0] b;
        b = 8'h00;
        if (a < 16'(DESC_BYTES)) b = DESC_IMAGE[a[DESC_AW-1:0]];
        return b;
    endfunction

endpackage

// File: rtl/usb_desc_rom.sv
// Synchronous-read descriptor ROM. The image is compiled in from the package;
// ROM_FILE names that image, and an empty name yields an erased (0xFF) ROM.
module usb_desc_rom
    import usb_ctl_pkg::*;
#(
    parameter int    ROM_AW   = 8,
    parameter string ROM_FILE = "usb_desc.mem"
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [7:0]        q
);

    logic [7:0] data_q;

    // NOTE: the ROM read register has no reset; it maps onto a block-RAM read
    // port, and consumers gate its output until a read has been issued.
    generate
        if (ROM_FILE != "") begin : g_image
            always_ff @(posedge clk) begin
                data_q <= desc_byte(16'(addr));
            end
        end else begin : g_erased
            always_ff @(posedge clk) begin
                data_q <= 8'hFF;
            end
        end
    endgenerate

    assign q = data_q;

endmodule

// File: rtl/usb_ctl_request.sv
// Endpoint-0 standard-request engine: decodes SETUP, streams IN data from the
// descriptor ROM or a status mux, drains OUT data, commits address/config after status.
module usb_ctl_request
    import usb_ctl_pkg::*;
#(
    parameter int    ROM_AW   = 8,
    parameter string ROM_FILE = "usb_desc.mem",
    parameter bit    SELF_PWR = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctl_start,
    input  logic [3:0]  ctl_endpoint,
    input  logic [7:0]  ctl_request_type,
    input  logic [7:0]  ctl_request,
    input  logic [15:0] ctl_value,
    input  logic [15:0] ctl_index,
    input  logic [15:0] ctl_length,
    input  logic        ctl_done,
    output logic [7:0]  xfer_tx_tdata,
    output logic        xfer_tx_tlast,
    output logic        xfer_tx_tvalid,
    input  logic        xfer_tx_tready,
    input  logic [7:0]  xfer_rx_tdata,
    input  logic        xfer_rx_tlast,
    input  logic        xfer_rx_tvalid,
    output logic        xfer_rx_tready,
    output logic        ctl_stall,
    output logic [6:0]  dev_addr,
    output logic [7:0]  dev_config,
    output logic        configured
);

    typedef logic [ROM_AW-1:0] rom_addr_t;

    ctl_state_e  state_q, state_d;
    setup_t      setup_q, setup_d;
    commit_e     commit_q, commit_d;
    logic        start_q;
    logic [15:0] remain_q, remain_d;
    rom_addr_t   ptr_q, ptr_d;
    rom_addr_t   rom_addr;
    logic        src_rom_q, src_rom_d;
    logic [15:0] stat_q, stat_d;
    logic [6:0]  pend_addr_q, pend_addr_d;
    logic [7:0]  pend_cfg_q, pend_cfg_d;
    logic [6:0]  dev_addr_q, dev_addr_d;
    logic [7:0]  dev_config_q, dev_config_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tready_q, tready_d;
    logic        stall_q, stall_d;
    logic        configured_q, configured_d;
    logic [7:0]  rom_q;

    logic start_rise, tx_beat, rx_beat;
    assign start_rise = ctl_start & ~start_q;
    assign tx_beat    = tvalid_q & xfer_tx_tready;
    assign rx_beat    = tready_q & xfer_rx_tvalid;

    // OUT data-stage bytes and wIndex carry nothing this engine acts on.
    logic unused_inputs;
    assign unused_inputs = ^{ctl_index, xfer_rx_tdata};

    usb_desc_rom #(
        .ROM_AW   (ROM_AW),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .q    (rom_q)
    );

    desc_entry_t desc;
    logic        std_req, dir_in;
    logic [4:0]  recipient;
    logic        dec_in_ok, dec_out_ok, dec_src_rom;
    logic [15:0] dec_len, dec_stat, dec_remain;

    always_comb begin
        desc        = desc_lookup(setup_q.value);
        std_req     = (setup_q.request_type[6:5] == 2'b00) && (setup_q.endpoint == 4'd0);
        dir_in      = setup_q.request_type[7];
        recipient   = setup_q.request_type[4:0];
        dec_in_ok   = 1'b0;
        dec_out_ok  = 1'b0;
        dec_src_rom = 1'b0;
        dec_len     = 16'd0;
        dec_stat    = 16'd0;
        if (std_req) begin
            case (setup_q.request)
                REQ_GET_DESCRIPTOR: begin
                    if (dir_in && desc.ok) begin
                        dec_in_ok   = 1'b1;
                        dec_src_rom = 1'b1;
                        dec_len     = desc.len;
                    end
                end
                REQ_GET_STATUS: begin
                    if (dir_in && recipient <= 5'd2) begin
                        dec_in_ok = 1'b1;
                        dec_len   = 16'd2;
                        dec_stat  = (recipient == 5'd0) ? {15'd0, SELF_PWR} : 16'd0;
                    end
                end
                REQ_GET_CONFIGURATION: begin
                    if (dir_in) begin
                        dec_in_ok = 1'b1;
                        dec_len   = 16'd1;
                        dec_stat  = {8'h00, dev_config_q};
                    end
                end
                REQ_SET_ADDRESS:       dec_out_ok = !dir_in;
                REQ_SET_CONFIGURATION: dec_out_ok = !dir_in && (setup_q.value[7:1] == 7'd0);
                default: ;
            endcase
        end
        dec_remain = (setup_q.length < dec_len) ? setup_q.length : dec_len;
    end

    // NOTE: every *_d gets its hold value first, so no path through the case
    // statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        setup_d      = setup_q;
        commit_d     = commit_q;
        remain_d     = remain_q;
        ptr_d        = ptr_q;
        src_rom_d    = src_rom_q;
        stat_d       = stat_q;
        pend_addr_d  = pend_addr_q;
        pend_cfg_d   = pend_cfg_q;
        dev_addr_d   = dev_addr_q;
        dev_config_d = dev_config_q;
        rom_addr     = ptr_q;

        if (start_rise) begin
            // A new SETUP overrides whatever was in flight, including pending commits.
            setup_d  = '{endpoint: ctl_endpoint, request_type: ctl_request_type,
                         request: ctl_request, value: ctl_value, length: ctl_length};
            commit_d = COMMIT_NONE;
            state_d  = ST_DECODE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DECODE: begin
                    state_d = ST_STALL;
                    if (dec_in_ok) begin
                        ptr_d     = rom_addr_t'(desc.ofs);
                        src_rom_d = dec_src_rom;
                        stat_d    = dec_stat;
                        remain_d  = dec_remain;
                        state_d   = (setup_q.length == 16'd0) ? ST_WAIT_DONE : ST_PREFETCH;
                    end else if (dec_out_ok) begin
                        if (setup_q.request == REQ_SET_ADDRESS) begin
                            pend_addr_d = setup_q.value[6:0];
                            commit_d    = COMMIT_ADDR;
                        end else begin
                            pend_cfg_d = setup_q.value[7:0];
                            commit_d   = COMMIT_CFG;
                        end
                        state_d = (setup_q.length != 16'd0) ? ST_DRAIN : ST_WAIT_DONE;
                    end
                end
                ST_PREFETCH: state_d = ST_SEND;
                ST_SEND: begin
                    // Look one byte ahead on a beat so the ROM keeps pace with tready.
                    if (tx_beat) begin
                        rom_addr = ptr_q + 1'b1;
                        ptr_d    = ptr_q + 1'b1;
                        remain_d = remain_q - 16'd1;
                        stat_d   = {8'h00, stat_q[15:8]};
                        if (tlast_q) state_d = ST_WAIT_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (rx_beat && xfer_rx_tlast) state_d = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (ctl_done) begin
                        if (commit_q == COMMIT_ADDR) dev_addr_d = pend_addr_q;
                        if (commit_q == COMMIT_CFG) dev_config_d = pend_cfg_q;
                        commit_d = COMMIT_NONE;
                        state_d  = ST_IDLE;
                    end
                end
                ST_STALL: ;
                default: state_d = ST_IDLE;
            endcase
        end

        tvalid_d     = (state_d == ST_SEND);
        tlast_d      = tvalid_d && (remain_d == 16'd1);
        tready_d     = (state_d == ST_DRAIN);
        stall_d      = (state_d == ST_STALL);
        configured_d = (dev_config_d != 8'd0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            setup_q      <= '0;
            commit_q     <= COMMIT_NONE;
            start_q      <= 1'b0;
            remain_q     <= 16'd0;
            ptr_q        <= '0;
            src_rom_q    <= 1'b0;
            stat_q       <= 16'd0;
            pend_addr_q  <= 7'd0;
            pend_cfg_q   <= 8'd0;
            dev_addr_q   <= 7'd0;
            dev_config_q <= 8'd0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tready_q     <= 1'b0;
            stall_q      <= 1'b0;
            configured_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            setup_q      <= setup_d;
            commit_q     <= commit_d;
            start_q      <= ctl_start;
            remain_q     <= remain_d;
            ptr_q        <= ptr_d;
            src_rom_q    <= src_rom_d;
            stat_q       <= stat_d;
            pend_addr_q  <= pend_addr_d;
            pend_cfg_q   <= pend_cfg_d;
            dev_addr_q   <= dev_addr_d;
            dev_config_q <= dev_config_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tready_q     <= tready_d;
            stall_q      <= stall_d;
            configured_q <= configured_d;
        end
    end

    assign xfer_tx_tdata  = !tvalid_q ? 8'h00 : (src_rom_q ? rom_q : stat_q[7:0]);
    assign xfer_tx_tlast  = tlast_q;
    assign xfer_tx_tvalid = tvalid_q;
    assign xfer_rx_tready = tready_q;
    assign ctl_stall      = stall_q;
    assign dev_addr       = dev_addr_q;
    assign dev_config     = dev_config_q;
    assign configured     = configured_q;

endmodule

// File: tb/tb_usb_ctl_request.sv
// Directed bench for usb_ctl_request: descriptor streaming, status/config requests,
// address commit timing, stalls, SETUP abort and asynchronous reset.
module tb_usb_ctl_request;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctl_start;
    logic [3:0]  ctl_endpoint;
    logic [7:0]  ctl_request_type;
    logic [7:0]  ctl_request;
    logic [15:0] ctl_value;
    logic [15:0] ctl_index;
    logic [15:0] ctl_length;
    logic        ctl_done;
    logic [7:0]  xfer_tx_tdata;
    logic        xfer_tx_tlast;
    logic        xfer_tx_tvalid;
    logic        xfer_tx_tready;
    logic [7:0]  xfer_rx_tdata;
    logic        xfer_rx_tlast;
    logic        xfer_rx_tvalid;
    logic        xfer_rx_tready;
    logic        ctl_stall;
    logic [6:0]  dev_addr;
    logic [7:0]  dev_config;
    logic        configured;

    always #5 clk = ~clk;

    usb_ctl_request #(
        .ROM_AW   (8),
        .ROM_FILE ("usb_desc.mem"),
        .SELF_PWR (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctl_start        (ctl_start),
        .ctl_endpoint     (ctl_endpoint),
        .ctl_request_type (ctl_request_type),
        .ctl_request      (ctl_request),
        .ctl_value        (ctl_value),
        .ctl_index        (ctl_index),
        .ctl_length       (ctl_length),
        .ctl_done         (ctl_done),
        .xfer_tx_tdata    (xfer_tx_tdata),
        .xfer_tx_tlast    (xfer_tx_tlast),
        .xfer_tx_tvalid   (xfer_tx_tvalid),
        .xfer_tx_tready   (xfer_tx_tready),
        .xfer_rx_tdata    (xfer_rx_tdata),
        .xfer_rx_tlast    (xfer_rx_tlast),
        .xfer_rx_tvalid   (xfer_rx_tvalid),
        .xfer_rx_tready   (xfer_rx_tready),
        .ctl_stall        (ctl_stall),
        .dev_addr         (dev_addr),
        .dev_config       (dev_config),
        .configured       (configured)
    );

    logic [7:0] dev_exp  [18] = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34,
                                  8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    logic [7:0] cfg_exp  [9]  = '{8'h09, 8'h02, 8'h22, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32};
    logic [7:0] str1_exp [10] = '{8'h0A, 8'h03, 8'h41, 8'h00, 8'h63, 8'h00, 8'h6D, 8'h00, 8'h65, 8'h00};

    int total = 0;
    int bad   = 0;

    int         nbeats, last_at, first_cyc, last_cyc, unstable;
    logic [7:0] rx_bytes [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_setup(input logic [7:0] rtype, input logic [7:0] req,
                            input logic [15:0] value, input logic [15:0] length);
        @(negedge clk);
        ctl_endpoint     = 4'd0;
        ctl_request_type = rtype;
        ctl_request      = req;
        ctl_value        = value;
        ctl_index        = 16'd0;
        ctl_length       = length;
        ctl_start        = 1'b1;
        @(negedge clk);
        ctl_start        = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        ctl_done = 1'b1;
        @(negedge clk);
        ctl_done = 1'b0;
    endtask

    // Accepts IN beats until tlast, max_beats, or max_cyc; tready is dropped afterwards.
    task automatic read_in(input int max_cyc, input bit rnd, input int max_beats);
        logic [7:0] held;
        bit         was_stalled;
        nbeats = 0; last_at = -1; first_cyc = -1; last_cyc = -1; unstable = 0;
        was_stalled = 1'b0; held = 8'h00;
        for (int i = 0; i < 256; i++) rx_bytes[i] = 8'hxx;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            xfer_tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (xfer_tx_tvalid) begin
                if (first_cyc < 0) first_cyc = c;
                if (was_stalled && xfer_tx_tdata !== held) unstable++;
                if (xfer_tx_tready) begin
                    rx_bytes[nbeats] = xfer_tx_tdata;
                    if (xfer_tx_tlast) last_at = nbeats;
                    nbeats++;
                    last_cyc    = c;
                    was_stalled = 1'b0;
                    if (xfer_tx_tlast || nbeats == max_beats) break;
                end else begin
                    was_stalled = 1'b1;
                    held        = xfer_tx_tdata;
                end
            end
        end
        @(negedge clk);
        xfer_tx_tready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_valid;
        rst_n = 1'b0;
        ctl_start = 1'b0; ctl_endpoint = 4'd0; ctl_request_type = 8'd0; ctl_request = 8'd0;
        ctl_value = 16'd0; ctl_index = 16'd0; ctl_length = 16'd0; ctl_done = 1'b0;
        xfer_tx_tready = 1'b0; xfer_rx_tdata = 8'd0; xfer_rx_tlast = 1'b0; xfer_rx_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_tvalid", 32'(xfer_tx_tvalid), 0);
        check("rst_tdata", 32'(xfer_tx_tdata), 0);
        check("rst_tlast", 32'(xfer_tx_tlast), 0);
        check("rst_rx_tready", 32'(xfer_rx_tready), 0);
        check("rst_stall", 32'(ctl_stall), 0);
        check("rst_dev_addr", 32'(dev_addr), 0);
        check("rst_dev_config", 32'(dev_config), 0);
        check("rst_configured", 32'(configured), 0);

        // GET_DESCRIPTOR(device), wLength 64 -> 18 bytes back-to-back
        do_setup(8'h80, 8'd6, 16'h0100, 16'd64);
        read_in(100, 1'b0, 256);
        check("t1_beats", 32'(nbeats), 18);
        check("t1_tlast_pos", 32'(last_at), 17);
        check("t1_no_bubble", 32'(last_cyc - first_cyc + 1), 18);
        for (int i = 0; i < 18; i++) check($sformatf("t1_byte%0d", i), 32'(rx_bytes[i]), 32'(dev_exp[i]));
        check("t1_idle_after", 32'(xfer_tx_tvalid), 0);
        pulse_done();

        // GET_DESCRIPTOR(config), wLength 9 truncates the 34-byte descriptor
        do_setup(8'h80, 8'd6, 16'h0200, 16'd9);
        read_in(300, 1'b1, 256);
        check("t2_beats", 32'(nbeats), 9);
        check("t2_tlast_pos", 32'(last_at), 8);
        check("t2_stable", 32'(unstable), 0);
        for (int i = 0; i < 9; i++) check($sformatf("t2_byte%0d", i), 32'(rx_bytes[i]), 32'(cfg_exp[i]));
        pulse_done();

        // SET_ADDRESS 0x2A commits only after the status stage
        do_setup(8'h00, 8'd5, 16'h002A, 16'd0);
        repeat (4) @(negedge clk);
        check("t3_addr_before", 32'(dev_addr), 0);
        ctl_done = 1'b1;
        check("t3_addr_at_done", 32'(dev_addr), 0);
        @(negedge clk);
        ctl_done = 1'b0;
        check("t3_addr_after", 32'(dev_addr), 32'h2A);

        // SET_CONFIGURATION 1, GET_CONFIGURATION, SET_CONFIGURATION 5
        do_setup(8'h00, 8'd9, 16'h0001, 16'd0);
        repeat (2) @(negedge clk);
        check("t4_cfg_before", 32'(configured), 0);
        pulse_done();
        check("t4_dev_config", 32'(dev_config), 1);
        check("t4_configured", 32'(configured), 1);
        do_setup(8'h80, 8'd8, 16'h0000, 16'd1);
        read_in(50, 1'b0, 256);
        check("t4_getcfg_beats", 32'(nbeats), 1);
        check("t4_getcfg_byte", 32'(rx_bytes[0]), 1);
        check("t4_getcfg_tlast", 32'(last_at), 0);
        pulse_done();
        do_setup(8'h00, 8'd9, 16'h0005, 16'd0);
        @(negedge clk);
        check("t4_bad_cfg_stall", 32'(ctl_stall), 1);
        pulse_done();
        check("t4_cfg_unchanged", 32'(dev_config), 1);

        // OUT data stage is drained, then the config commit still happens
        do_setup(8'h00, 8'd9, 16'h0001, 16'd2);
        @(negedge clk);
        check("t4_drain_tready", 32'(xfer_rx_tready), 1);
        xfer_rx_tvalid = 1'b1; xfer_rx_tdata = 8'hA5; xfer_rx_tlast = 1'b0;
        @(negedge clk);
        xfer_rx_tdata = 8'h5A; xfer_rx_tlast = 1'b1;
        @(negedge clk);
        xfer_rx_tvalid = 1'b0; xfer_rx_tlast = 1'b0;
        check("t4_drain_end", 32'(xfer_rx_tready), 0);
        pulse_done();
        check("t4_drain_configured", 32'(configured), 1);

        // Class request and out-of-range string index stall; next SETUP clears it
        do_setup(8'h21, 8'h09, 16'h0200, 16'd0);
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (xfer_tx_tvalid || xfer_rx_tready) seen_valid++;
        end
        check("t5_class_stall", 32'(ctl_stall), 1);
        check("t5_class_quiet", 32'(seen_valid), 0);
        do_setup(8'h80, 8'd6, 16'h0302, 16'd255);
        check("t5_stall_cleared", 32'(ctl_stall), 0);
        @(negedge clk);
        check("t5_str_stall", 32'(ctl_stall), 1);
        check("t5_str_no_valid", 32'(xfer_tx_tvalid), 0);
        do_setup(8'h80, 8'd6, 16'h0301, 16'd255);
        read_in(100, 1'b0, 256);
        check("t5_str1_beats", 32'(nbeats), 10);
        for (int i = 0; i < 10; i++) check($sformatf("t5_str1_byte%0d", i), 32'(rx_bytes[i]), 32'(str1_exp[i]));
        pulse_done();
        do_setup(8'h80, 8'd0, 16'h0000, 16'd2);
        read_in(50, 1'b0, 256);
        check("t5_status_beats", 32'(nbeats), 2);
        check("t5_status_b0", 32'(rx_bytes[0]), 1);
        check("t5_status_b1", 32'(rx_bytes[1]), 0);
        pulse_done();

        // New SETUP after 4 device-descriptor beats aborts and restarts cleanly
        do_setup(8'h80, 8'd6, 16'h0100, 16'd64);
        read_in(50, 1'b0, 4);
        check("t6_partial_beats", 32'(nbeats), 4);
        check("t6_valid_held", 32'(xfer_tx_tvalid), 1);
        do_setup(8'h80, 8'd6, 16'h0200, 16'd9);
        check("t6_abort_drop", 32'(xfer_tx_tvalid), 0);
        read_in(100, 1'b0, 256);
        check("t6_new_beats", 32'(nbeats), 9);
        for (int i = 0; i < 9; i++) check($sformatf("t6_byte%0d", i), 32'(rx_bytes[i]), 32'(cfg_exp[i]));
        pulse_done();

        // Asynchronous reset in the middle of a data stage
        do_setup(8'h80, 8'd6, 16'h0100, 16'd64);
        read_in(50, 1'b0, 3);
        check("t6_pre_rst_valid", 32'(xfer_tx_tvalid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 32'(xfer_tx_tvalid), 0);
        check("t6_rst_tdata", 32'(xfer_tx_tdata), 0);
        check("t6_rst_tlast", 32'(xfer_tx_tlast), 0);
        check("t6_rst_dev_addr", 32'(dev_addr), 0);
        check("t6_rst_dev_config", 32'(dev_config), 0);
        check("t6_rst_configured", 32'(configured), 0);
        check("t6_rst_stall", 32'(ctl_stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
